// File: rtl/cbm2_bus_sched_if.sv
// ---------------------------------------------------------------------------
// cbm2_bus_sched_if
//
// Groups the control inputs and slot/strobe outputs of the CBM-II bus-slot
// scheduler so that cbm2_main and the scheduler share a single connection.
//
// master modport (scheduler side):
//   inputs  : pause, sys2mhz
//   outputs : pause_out, cycle[4:0], refresh, ext_cycle, cpu_cycle,
//             cop_cycle, vid_cycle, en_cpu, en_cop, en_vid, en_io_n,
//             en_io_p, ram_slot_ce, phase, vic_pixel, crtc_pixel
// slave modport (consumer side): the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface cbm2_bus_sched_if;
    logic       pause;
    logic       sys2mhz;
    logic       pause_out;
    logic [4:0] cycle;
    logic       refresh;
    logic       ext_cycle;
    logic       cpu_cycle;
    logic       cop_cycle;
    logic       vid_cycle;
    logic       en_cpu;
    logic       en_cop;
    logic       en_vid;
    logic       en_io_n;
    logic       en_io_p;
    logic       ram_slot_ce;
    logic       phase;
    logic       vic_pixel;
    logic       crtc_pixel;

    modport master (
        input  pause, sys2mhz,
        output pause_out, cycle, refresh, ext_cycle, cpu_cycle, cop_cycle,
               vid_cycle, en_cpu, en_cop, en_vid, en_io_n, en_io_p,
               ram_slot_ce, phase, vic_pixel, crtc_pixel
    );

    modport slave (
        output pause, sys2mhz,
        input  pause_out, cycle, refresh, ext_cycle, cpu_cycle, cop_cycle,
               vid_cycle, en_cpu, en_cop, en_vid, en_io_n, en_io_p,
               ram_slot_ce, phase, vic_pixel, crtc_pixel
    );
endinterface

// File: rtl/cbm2_bus_sched.sv
// ---------------------------------------------------------------------------
// cbm2_bus_sched
//
// Central bus-slot scheduler for the CBM-II core. A 5-bit phase counter
// divides each 1 MHz period (32 clk_sys clocks) into 32 slots owned in turn
// by the external/SDRAM port, the CPU, the co-CPU and video. The scheduler
// emits slot ownership, one-clock enable strobes, the SDRAM access start
// strobe and a refresh request once per refresh frame.
//
// Ports:
//   clk_sys  - system clock, 32 clocks per 1 MHz period
//   reset_n  - synchronous active-low reset
//   bus      - cbm2_bus_sched_if.master (pause/sys2mhz in, decodes out)
//
// Parameter:
//   RFSH_DIV - frames per SDRAM refresh frame (power of two, >= 2)
//
// Build option:
//   CBM2_SCHED_COP_EN - when defined, the co-CPU slots (8-11, 24-27) are
//   decoded and start SDRAM accesses; otherwise they stay idle and no co-CPU
//   logic exists.
// ---------------------------------------------------------------------------
module cbm2_bus_sched #(
    parameter int unsigned RFSH_DIV = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    cbm2_bus_sched_if.master bus
);

    localparam int RW = $clog2(RFSH_DIV);

    typedef enum logic {
        SCHED_HALT = 1'b0,
        SCHED_RUN  = 1'b1
    } sched_state_e;

    sched_state_e   state_q, state_d;
    logic [4:0]     pre_q, pre_d;
    logic [RW-1:0]  rcnt_q, rcnt_d;
    logic           s2_q, s2_d;
    logic           refresh_q, refresh_d;

    // Next-state logic. Pause is only sampled at the refresh decision point
    // (pre=15 of the refresh frame) so entry and exit stay frame aligned.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        pre_d     = pre_q + 5'd1;
        rcnt_d    = rcnt_q;
        state_d   = state_q;
        s2_d      = s2_q;
        refresh_d = 1'b0;

        // The 2 MHz choice is frozen just before the first CPU slot so that
        // slots 4-11 of a frame see one consistent setting.
        if (pre_q == 5'd3) begin
            s2_d = bus.sys2mhz;
        end

        // rcnt only advances while running, so a halted scheduler sits in a
        // refresh frame and re-evaluates pause every 32 clocks.
        if (pre_q == 5'd31 && state_q == SCHED_RUN) begin
            rcnt_d = rcnt_q + RW'(1);
        end

        if (pre_q == 5'd15 && rcnt_q == '0) begin
            refresh_d = 1'b1;
            state_d   = bus.pause ? SCHED_HALT : SCHED_RUN;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values that existed before the clock edge.
    always_ff @(posedge clk_sys) begin
        // NOTE: all state is reset explicitly; there is no storage array here
        // that would make a reset impractical.
        if (!reset_n) begin
            state_q   <= SCHED_HALT;
            pre_q     <= 5'd0;
            rcnt_q    <= '0;
            s2_q      <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            rcnt_q    <= rcnt_d;
            s2_q      <= s2_d;
            refresh_q <= refresh_d;
        end
    end

    // Slot decode. A halted scheduler parks the visible slot at 16, which
    // belongs to no active owner once the run gate below is applied.
    logic       run;
    logic [4:0] cyc;
    logic [1:0] grp;      // 0 EXT, 1 CPU, 2 COP, 3 VID within a half-frame
    logic [1:0] off;      // clock within the 4-clock slot
    logic       fast;     // CPU/COP slot is live: second half, or 2 MHz mode

    assign run  = (state_q == SCHED_RUN);
    assign cyc  = run ? pre_q : 5'd16;
    assign grp  = cyc[3:2];
    assign off  = cyc[1:0];
    assign fast = cyc[4] | s2_q;

    always_comb begin
        bus.ext_cycle   = 1'b0;
        bus.cpu_cycle   = 1'b0;
        bus.cop_cycle   = 1'b0;
        bus.vid_cycle   = 1'b0;
        bus.en_cpu      = 1'b0;
        bus.en_cop      = 1'b0;
        bus.en_vid      = 1'b0;
        bus.en_io_n     = 1'b0;
        bus.en_io_p     = 1'b0;
        bus.ram_slot_ce = 1'b0;
        if (run) begin
            // Refresh frames give the second EXT slot to the SDRAM refresh.
            bus.ext_cycle   = (grp == 2'd0) && (!cyc[4] || rcnt_q != '0);
            bus.cpu_cycle   = (grp == 2'd1) && fast;
            bus.vid_cycle   = (grp == 2'd3);
            bus.en_vid      = (grp == 2'd3) && (off == 2'd3);
            bus.en_io_n     = (grp == 2'd1) && (off == 2'd2) && fast;
            bus.en_cpu      = (grp == 2'd1) && (off == 2'd3) && fast;
            bus.en_io_p     = (grp == 2'd2) && (off == 2'd0) && fast;
            bus.ram_slot_ce = (off == 2'd0) &&
                              ((grp == 2'd3) || (grp == 2'd1 && fast));
`ifdef CBM2_SCHED_COP_EN
            bus.cop_cycle   = (grp == 2'd2) && fast;
            bus.en_cop      = (grp == 2'd2) && (off == 2'd3) && fast;
            if (grp == 2'd2 && off == 2'd0 && fast) begin
                bus.ram_slot_ce = 1'b1;
            end
`endif
        end
    end

    assign bus.cycle      = cyc;
    assign bus.pause_out  = ~run;
    assign bus.refresh    = refresh_q;
    assign bus.phase      = cyc[4];
    assign bus.vic_pixel  = cyc[1] & cyc[0];
    assign bus.crtc_pixel = cyc[0];

endmodule

// File: tb/tb_cbm2_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_cbm2_bus_sched
//
// Self-checking bench for cbm2_bus_sched. A behavioural model tracks the slot
// position, the count of completed running frames and the run/2 MHz flags as
// plain integers, and derives every expected output from the slot tables.
// Directed phases cover reset, start-up, refresh cadence, 2 MHz switching,
// pause entry/exit and mid-run reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_cbm2_bus_sched;

    localparam int RFSH_DIV = 4;
`ifdef CBM2_SCHED_COP_EN
    localparam bit COP = 1'b1;
`else
    localparam bit COP = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk_sys = ~clk_sys;

    cbm2_bus_sched_if bus ();

    cbm2_bus_sched #(.RFSH_DIV(RFSH_DIV)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pos    = 0;    // position within the 32-clock frame
    int m_frames = 0;    // completed running frames since reset
    bit m_run    = 1'b0;
    bit m_s2     = 1'b0;
    bit m_rf     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit inr(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Advance the model across one clock edge using the inputs held there.
    task automatic model_edge();
        bit decide;
        if (!reset_n) begin
            m_pos = 0; m_frames = 0; m_run = 1'b0; m_s2 = 1'b0; m_rf = 1'b0;
        end else begin
            decide = (m_pos == 15) && (m_frames % RFSH_DIV == 0);
            m_rf = decide;
            if (m_pos == 3) m_s2 = bus.sys2mhz;
            if (m_pos == 31 && m_run) m_frames++;
            if (decide) m_run = !bus.pause;
            m_pos = (m_pos + 1) % 32;
        end
    endtask

    task automatic check_outputs();
        int c;
        bit r, ext, cpu, cop, vid, ecpu, ecop, evid, ion, iop, ram;
        r    = m_run;
        c    = r ? m_pos : 16;
        ext  = r && (inr(c, 0, 3) || (inr(c, 16, 19) && (m_frames % RFSH_DIV != 0)));
        cpu  = r && (inr(c, 20, 23) || (m_s2 && inr(c, 4, 7)));
        cop  = COP && r && (inr(c, 24, 27) || (m_s2 && inr(c, 8, 11)));
        vid  = r && (inr(c, 12, 15) || inr(c, 28, 31));
        evid = r && (c == 15 || c == 31);
        ion  = r && (c == 22 || (m_s2 && c == 6));
        ecpu = r && (c == 23 || (m_s2 && c == 7));
        iop  = r && (c == 24 || (m_s2 && c == 8));
        ecop = COP && r && (c == 27 || (m_s2 && c == 11));
        ram  = r && (c == 12 || c == 20 || c == 28 || (m_s2 && c == 4) ||
                     (COP && (c == 24 || (m_s2 && c == 8))));
        check("cycle", bus.cycle, c);
        check("pause_out", bus.pause_out, !r);
        check("refresh", bus.refresh, m_rf);
        check("slots{ext,cpu,cop,vid}",
              {bus.ext_cycle, bus.cpu_cycle, bus.cop_cycle, bus.vid_cycle},
              {ext, cpu, cop, vid});
        check("strobes{cpu,cop,vid,io_n,io_p,ram}",
              {bus.en_cpu, bus.en_cop, bus.en_vid, bus.en_io_n, bus.en_io_p, bus.ram_slot_ce},
              {ecpu, ecop, evid, ion, iop, ram});
        check("pixels{phase,vic,crtc}",
              {bus.phase, bus.vic_pixel, bus.crtc_pixel},
              {c >= 16, (c % 4) == 3, (c % 2) == 1});
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic align(input int pos);
        for (int i = 0; i < 32 && m_pos != pos; i++) step();
    endtask

    // Counts over the 32 periods starting at the current one.
    task automatic run_frame(output int ext_n, output int cpu_n, output int ecpu_n, output int rf_n);
        ext_n = 0; cpu_n = 0; ecpu_n = 0; rf_n = 0;
        for (int k = 0; k < 32; k++) begin
            ext_n  += int'(bus.ext_cycle);
            cpu_n  += int'(bus.cpu_cycle);
            ecpu_n += int'(bus.en_cpu);
            rf_n   += int'(bus.refresh);
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, ext_n, cpu_n, ecpu_n, rf_n, rf_total, act;
        int rf_time[$];
        int t;

        bus.pause   = 1'b0;
        bus.sys2mhz = 1'b0;
        reset_n     = 1'b0;

        // Reset state
        repeat (3) step();
        check("reset_cycle", bus.cycle, 16);
        check("reset_pause_out", bus.pause_out, 1);

        // Start-up: refresh appears in the 17th period after release
        reset_n = 1'b1;
        n = 1;
        while (!bus.refresh && n < 64) begin step(); n++; end
        check("first_refresh_period", n, 17);
        check("first_run_cycle", bus.cycle, 16);

        // Refresh cadence over 512 clocks
        align(0);
        rf_total = 0;
        t = 0;
        for (int f = 0; f < 16; f++) begin
            ext_n = 0; rf_n = 0;
            for (int k = 0; k < 32; k++) begin
                ext_n += int'(bus.ext_cycle);
                if (bus.refresh) begin rf_n++; rf_time.push_back(t); end
                t++;
                step();
            end
            rf_total += rf_n;
            check("ext_per_frame", ext_n, (rf_n != 0) ? 4 : 8);
        end
        check("refresh_count_512", rf_total, 4);
        for (int i = 1; i < rf_time.size(); i++)
            check("refresh_spacing", rf_time[i] - rf_time[i-1], 128);

        // 2 MHz held
        bus.sys2mhz = 1'b1;
        align(0);
        run_frame(ext_n, cpu_n, ecpu_n, rf_n);
        run_frame(ext_n, cpu_n, ecpu_n, rf_n);
        check("cpu_cycle_2mhz", cpu_n, 8);
        check("en_cpu_2mhz", ecpu_n, 2);

        // Back to 1 MHz, then switch on at pre=5: no effect until next frame
        bus.sys2mhz = 1'b0;
        align(0);
        run_frame(ext_n, cpu_n, ecpu_n, rf_n);
        check("cpu_cycle_1mhz", cpu_n, 4);
        align(5);
        bus.sys2mhz = 1'b1;
        n = 0;
        for (int k = 5; k < 32; k++) begin n += int'(bus.en_cpu); step(); end
        check("en_cpu_after_late_switch", n, 1);
        run_frame(ext_n, cpu_n, ecpu_n, rf_n);
        check("en_cpu_next_frame", ecpu_n, 2);
        bus.sys2mhz = 1'b0;

        // Pause at pre=20 of a non-refresh frame
        for (int i = 0; i < 300 && !(m_pos == 20 && m_run && (m_frames % RFSH_DIV != 0)); i++) step();
        bus.pause = 1'b1;
        n = 0;
        while (!bus.pause_out && n < 300) begin step(); n++; end
        check("pause_entered", bus.pause_out, 1);
        check("pause_entry_refresh", bus.refresh, 1);
        rf_n = 0; act = 0;
        repeat (96) begin
            step();
            rf_n += int'(bus.refresh);
            act  += int'(bus.ext_cycle | bus.cpu_cycle | bus.cop_cycle | bus.vid_cycle |
                         bus.en_cpu | bus.en_cop | bus.en_vid | bus.en_io_n |
                         bus.en_io_p | bus.ram_slot_ce);
        end
        check("paused_refresh_count", rf_n, 3);
        check("paused_activity", act, 0);
        bus.pause = 1'b0;
        n = 1;
        while (bus.pause_out && n < 64) begin step(); n++; end
        check("resumed", bus.pause_out, 0);
        n = 1;
        while (!bus.en_cpu && n < 64) begin step(); n++; end
        check("resume_to_en_cpu_periods", n, 8);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.sys2mhz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) bus.pause = ~bus.pause;
            step();
        end
        bus.pause   = 1'b0;
        bus.sys2mhz = 1'b0;

        // Make sure the scheduler is running, then reset at pre=25
        n = 0;
        while (bus.pause_out && n < 300) begin step(); n++; end
        align(25);
        reset_n = 1'b0;
        step();
        check("midrun_reset_cycle", bus.cycle, 16);
        check("midrun_reset_pause_out", bus.pause_out, 1);
        check("midrun_reset_refresh", bus.refresh, 0);
        reset_n = 1'b1;
        n = 1;
        while (!bus.refresh && n < 64) begin step(); n++; end
        check("restart_refresh_period", n, 17);
        repeat (64) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbm2_bus_sched.md
Name: cbm2_bus_sched

Overview:
- Central bus-slot scheduler for the CBM-II core.
- Runs a 32-phase system cycle per 1 MHz period and decodes slot ownership (external/SDRAM, CPU, co-CPU, video).
- Generates the one-clock enable strobes for the CPU, I/O chips and video, plus SDRAM chip-enable and refresh.
- Handles 1/2 MHz slot selection and frame-aligned pause entry and exit; cbm2_main consumes its outputs in place of local slot decode.

Parameters:
- RFSH_DIV, 4: frames (32 clocks each) per SDRAM refresh frame; power of two, at least 2.

Ports:
- clk_sys  in  1  system clock, 32 clocks per 1 MHz period
- reset_n  in  1  synchronous active-low reset
- pause  in  1  pause request
- sys2mhz  in  1  request 2 MHz CPU/co-CPU slots in the first half-frame
- pause_out  out  1  scheduler halted
- cycle  out  5  current slot; 0-3 EXT0-3, 4-7 CPU0-3, 8-11 COP0-3, 12-15 VID0-3, 16-19 EXT4-7, 20-23 CPU4-7, 24-27 COP4-7, 28-31 VID4-7
- refresh  out  1  one-clock SDRAM refresh request
- ext_cycle  out  1  SDRAM slot free for the external port
- cpu_cycle, cop_cycle, vid_cycle  out  1 each  slot ownership
- en_cpu, en_cop, en_vid, en_io_n, en_io_p  out  1 each  one-clock strobes
- ram_slot_ce  out  1  SDRAM access start strobe
- phase  out  1  equals cycle[4]
- vic_pixel  out  1  equals cycle[1] AND cycle[0]
- crtc_pixel  out  1  equals cycle[0]

Behaviour:
- State:
  - pre: 5-bit free-running counter, wraps 31 to 0.
  - rcnt: log2(RFSH_DIV)-bit frame counter.
  - en: scheduler running.
  - s2: 2 MHz latch.
  - refresh: registered.
- Reset (reset_n low at a clock edge):
  - pre=0, rcnt=0, en=0, s2=0, refresh=0.
  - Consequently cycle=16, pause_out=1, and all strobes and slot outputs are 0.
- cycle = pre when en=1, else 16. pause_out = NOT en. All decodes below are combinational from cycle, s2 and rcnt.
- When en=0, every decode output is 0: phase=1, pixel strobes 0, ext_cycle 0, ram_slot_ce 0.
- s2 <= sys2mhz on the edge where pre goes 3 to 4. It governs slots 4-11 of that frame; changes to sys2mhz at any other time have no effect until the next such edge.
- At pre=31, rcnt increments (with wrap) only if en=1.
- At pre=15 with rcnt=0:
  - refresh <= 1, so refresh is high exactly while pre=16.
  - en <= NOT pause.
  - Otherwise refresh <= 0.
- Pause timing:
  - Pause entry and exit occur only at refresh-frame boundaries.
  - While paused, rcnt holds at 0, so refresh pulses every 32 clocks and pause is re-sampled every frame.
- Slot decodes (en=1):
  - ext_cycle: cycle 0-3, or cycle 16-19 when rcnt is not 0. Refresh frames reserve slots 16-19.
  - cpu_cycle: 20-23, or 4-7 when s2=1.
  - cop_cycle: 24-27, or 8-11 when s2=1 (see Optional Feature).
  - vid_cycle: 12-15 or 28-31.
- Strobes (en=1):
  - en_vid: cycle 15 or 31.
  - en_io_n: 22, or 6 when s2=1.
  - en_cpu: 23, or 7 when s2=1.
  - en_io_p: 24, or 8 when s2=1.
  - en_cop: 27, or 11 when s2=1.
  - ram_slot_ce: 12, 20, 28, or 4 when s2=1. With COP_EN, also 24, or 8 when s2=1.
- Simultaneous events:
  - pause toggling on the decision edge uses the value sampled at that edge.
  - reset_n has priority over every update.

Optional Feature:
- Macro: CBM2_SCHED_COP_EN.
- Defined:
  - cop_cycle and en_cop decode as specified.
  - ram_slot_ce includes the co-CPU slot starts.
- Undefined:
  - cop_cycle=0 and en_cop=0 permanently.
  - Slots 8-11 and 24-27 are idle; ram_slot_ce never fires in them.
  - No co-CPU logic is synthesised.

Test Plan:
- Reset release, pause=0, sys2mhz=0, RFSH_DIV=4:
  - first refresh=1 on the 17th clock after release (pre=16);
  - cycle=16 until then, then follows pre;
  - en_cpu only at cycle 23, en_vid at 15 and 31, ram_slot_ce at 12, 20, 28.
- sys2mhz=1 held:
  - from the next frame, en_cpu at 7 and 23, en_io_n at 6 and 22, en_io_p at 8 and 24;
  - cpu_cycle high 8 clocks per frame.
- Refresh cadence over 512 clocks:
  - refresh pulses exactly 4 times, 128 clocks apart;
  - ext_cycle high 8 clocks in non-refresh frames and 4 clocks in the refresh frame.
- pause=1 asserted at pre=20 of a non-refresh frame:
  - scheduler keeps running until the next rcnt=0 pre=15 edge;
  - then cycle=16, pause_out=1, all enables 0, refresh still every 32 clocks;
  - deassert pause and the scheduler resumes at the following refresh decision, with the first en_cpu 8 clocks later.
- sys2mhz toggled 0 to 1 at pre=5: no 2 MHz strobes in the current frame; en_cpu at 7 in the next frame.
- reset_n low for 1 clock at pre=25 mid-run: next clock pre=0, cycle=16, pause_out=1, refresh=0; the normal restart sequence follows.
